// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// NUM_REQ requesters. Accepts one word per frame (valid/ready), issues a
// one-cycle start, holds the word for the whole frame, releases on tx_done.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES); otherwise o_timeout_err is tied to 0.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_req_valid [NUM_REQ] per-requester word pending
//   i_req_data            requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready [NUM_REQ] one-hot one-cycle accept pulse
//   o_frame_done[NUM_REQ] one-hot one-cycle frame-complete pulse
//   o_tx_start            to transmitter TX_START
//   o_tx_data_out         to transmitter TX_DATA_IN
//   i_tx_done             from transmitter TX_DONE
//   o_busy                high in LAUNCH and WAIT
//   o_grant_id            current / last granted requester
//   o_timeout_err         one-cycle watchdog pulse
module uart_tx_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_frame_done,
  output logic                          o_tx_start,
  output logic [DATA_WIDTH-1:0]         o_tx_data_out,
  input  logic                          i_tx_done,
  output logic                          o_busy,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_timeout_err
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [GW-1:0]         r_ptr, w_ptr_nxt;
  logic [GW-1:0]         r_grant_id, w_grant_id_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt;
  logic [NUM_REQ-1:0]    r_req_ready, w_req_ready_nxt;
  logic [NUM_REQ-1:0]    r_frame_done, w_frame_done_nxt;
  logic                  r_tx_start, w_tx_start_nxt;
  logic                  r_busy, w_busy_nxt;

  logic                  w_found;
  int                    w_idx;
  int                    w_win_idx;
  logic [GW-1:0]         w_winner;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_timeout_err, w_timeout_err_nxt;
`else
  logic                  w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Round-robin search: first valid bit from r_ptr+1 upward, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_idx     = 0;
    w_win_idx = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_idx = (int'(r_ptr) + k) % int'(NUM_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found   = 1'b1;
        w_win_idx = w_idx;
      end
    end
    w_winner = GW'(w_win_idx);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_grant_id_nxt   = r_grant_id;
    w_tx_data_nxt    = r_tx_data;
    w_req_ready_nxt  = '0;
    w_frame_done_nxt = '0;
    w_tx_start_nxt   = 1'b0;
    w_busy_nxt       = r_busy;
`ifdef UART_ARB_TIMEOUT_EN
    w_cnt_nxt         = r_cnt;
    w_timeout_err_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_id_nxt  = w_winner;
          w_tx_data_nxt   = i_req_data[w_win_idx*int'(DATA_WIDTH) +: DATA_WIDTH];
          w_req_ready_nxt = NUM_REQ'(1) << w_winner;
          w_tx_start_nxt  = 1'b1;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
`ifdef UART_ARB_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // tx_data is held: the transmitter computes parity from its live input.
        if (i_tx_done) begin
          w_ptr_nxt                    = r_grant_id;
          w_frame_done_nxt[r_grant_id] = 1'b1;
          w_busy_nxt                   = 1'b0;
          w_state_nxt                  = S_IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_timeout_err_nxt = 1'b1;
          w_ptr_nxt         = r_grant_id;
          w_busy_nxt        = 1'b0;
          w_state_nxt       = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= GW'(NUM_REQ - 1);
      r_grant_id   <= GW'(NUM_REQ - 1);
      r_tx_data    <= '0;
      r_req_ready  <= '0;
      r_frame_done <= '0;
      r_tx_start   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Watchdog counter and error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end
  assign o_timeout_err = r_timeout_err;
`else
  assign o_timeout_err = 1'b0;
`endif

  assign o_req_ready   = r_req_ready;
  assign o_frame_done  = r_frame_done;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data_out = r_tx_data;
  assign o_busy        = r_busy;
  assign o_grant_id    = r_grant_id;

endmodule
